// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_loader
// Brief    : Byte-stream boot loader. Waits for a sync byte, reads a 16-bit
//            little-endian halfword count, writes that many halfwords into
//            instruction RAM, then verifies an 8-bit additive checksum.
//            The core fetch path is held stalled until the image is accepted.
// Revision : 1.0 - initial release
// ============================================================================
module instr_loader #(
    parameter int         DEPTH     = 1024,
    parameter int         ADDR_W    = 10,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_byte_valid,
    input  logic [7:0]        i_byte,
    output logic              o_byte_ready,
    input  logic              i_restart,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [15:0]       o_wr_data,
    output logic              o_core_stall,
    output logic              o_done,
    output logic              o_error
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN_LO  = 3'd1,
        LEN_HI  = 3'd2,
        DATA_LO = 3'd3,
        DATA_HI = 3'd4,
        CSUM    = 3'd5,
        DONE    = 3'd6,
        ERROR   = 3'd7
    } state_t;

    // One extra bit on the halfword counter so a full DEPTH count fits.
    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t          state;
    state_t          state_nxt;
    logic            accept;
    logic [7:0]      len_lo;
    logic [15:0]     len_full;
    logic [ADDR_W:0] len_n;
    logic [ADDR_W:0] k;
    logic [ADDR_W:0] k_inc;
    logic [7:0]      lo_byte;
    logic [7:0]      csum;

    // Ready is withheld only once the image is finished (accepted or rejected).
    assign o_byte_ready = (state != DONE) && (state != ERROR);
    assign o_core_stall = (state != DONE);
    assign accept       = i_byte_valid && o_byte_ready;
    assign len_full     = {i_byte, len_lo};
    assign k_inc        = k + ONE;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; all loading transitions advance only on an accepted byte.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && (i_byte == SYNC_BYTE)) state_nxt = LEN_LO;
            end
            LEN_LO: begin
                if (accept) state_nxt = LEN_HI;
            end
            LEN_HI: begin
                if (accept) begin
                    if (int'({16'd0, len_full}) > DEPTH) state_nxt = ERROR;
                    else if (len_full == 16'd0)         state_nxt = CSUM;
                    else                                 state_nxt = DATA_LO;
                end
            end
            DATA_LO: begin
                if (accept) state_nxt = DATA_HI;
            end
            DATA_HI: begin
                if (accept) state_nxt = (k_inc == len_n) ? CSUM : DATA_LO;
            end
            CSUM: begin
                if (accept) state_nxt = (i_byte == csum) ? DONE : ERROR;
            end
            DONE, ERROR: begin
                if (i_restart) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: length capture, halfword assembly, RAM write strobe and checksum.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            len_lo    <= 8'd0;
            len_n     <= '0;
            k         <= '0;
            lo_byte   <= 8'd0;
            csum      <= 8'd0;
            o_wr_en   <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= 16'd0;
            o_done    <= 1'b0;
            o_error   <= 1'b0;
        end else begin
            o_wr_en <= 1'b0;
            o_done  <= (state_nxt == DONE);
            o_error <= (state_nxt == ERROR);
            if (accept) begin
                case (state)
                    IDLE: begin
                        if (i_byte == SYNC_BYTE) begin
                            csum <= 8'd0;
                            k    <= '0;
                        end
                    end
                    LEN_LO:  len_lo <= i_byte;
                    // Count already range-checked by the FSM, so truncation is safe.
                    LEN_HI:  len_n  <= len_full[ADDR_W:0];
                    DATA_LO: begin
                        lo_byte <= i_byte;
                        csum    <= csum + i_byte;
                    end
                    DATA_HI: begin
                        o_wr_en   <= 1'b1;
                        o_wr_addr <= k[ADDR_W-1:0];
                        o_wr_data <= {i_byte, lo_byte};
                        k         <= k_inc;
                        csum      <= csum + i_byte;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
